// File: rtl/raw_line_buffer_if.sv
// Raw Bayer stream in, line-paired pixel stream out.
interface raw_line_buffer_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned ADDR_W = 11
);
    logic [DATA_W-1:0] iDATA;
    logic              iDVAL;
    logic              iFVAL;

    logic [DATA_W-1:0] oD0;
    logic [DATA_W-1:0] oD1;
    logic              oX;
    logic              oY;
    logic              oDVAL;
    logic [ADDR_W-1:0] oX_CNT;
    logic [15:0]       oY_CNT;
    logic              oOVF;

    // Source side: drives the sensor stream, observes the paired output.
    modport master (
        output iDATA, iDVAL, iFVAL,
        input  oD0, oD1, oX, oY, oDVAL, oX_CNT, oY_CNT, oOVF
    );

    // Line buffer side.
    modport slave (
        input  iDATA, iDVAL, iFVAL,
        output oD0, oD1, oX, oY, oDVAL, oX_CNT, oY_CNT, oOVF
    );
endinterface

// File: rtl/raw_line_buffer.sv
// Bayer line pairing: each accepted pixel is emitted one cycle later together
// with the pixel from the same column of the previous line.
module raw_line_buffer #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned LINE_MAX = 2048,
    parameter int unsigned ADDR_W   = 11
) (
    input  logic            CLK,
    input  logic            RST_N,
    raw_line_buffer_if.slave bus
);
    localparam int unsigned ROW_W = 16;
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_MAX - 1);

    logic [DATA_W-1:0] mem [0:LINE_MAX-1];

    logic              fval_q;
    logic              dval_q;
    logic [ADDR_W-1:0] col_q;
    logic [ROW_W-1:0]  row_q;
    logic              full_q;
    logic              first_q;

    logic              accept;
    logic              frame_start;
    logic              eol;
    logic [ADDR_W-1:0] col_eff;
    logic [ROW_W-1:0]  row_eff;
    logic              full_eff;
    logic              first_eff;
    logic              wr_en;

    logic [ADDR_W-1:0] col_d;
    logic [ROW_W-1:0]  row_d;
    logic              full_d;
    logic              first_d;
    logic              ovf_d;

    // Frame/line event detection and counter next-state.
    always_comb begin
        accept      = bus.iDVAL & bus.iFVAL;
        frame_start = bus.iFVAL & ~fval_q;
        eol         = dval_q & ~bus.iDVAL & bus.iFVAL;

        // A frame start applies to a pixel arriving in the same cycle.
        col_eff   = frame_start ? '0 : col_q;
        row_eff   = frame_start ? '0 : row_q;
        full_eff  = frame_start ? 1'b0 : full_q;
        first_eff = frame_start | first_q;

        // Past the last RAM column the history must not be overwritten.
        wr_en = accept & ~full_eff;

        col_d   = col_eff;
        row_d   = row_eff;
        full_d  = full_eff;
        first_d = first_eff;
        ovf_d   = frame_start ? 1'b0 : bus.oOVF;

        if (accept) begin
            if (col_eff == COL_LAST) begin
                full_d = 1'b1;
            end else begin
                col_d = col_eff + ADDR_W'(1);
            end
            if (full_eff) begin
                ovf_d = 1'b1;
            end
        end

        if (eol) begin
            col_d   = '0;
            row_d   = row_q + ROW_W'(1);
            full_d  = 1'b0;
            first_d = 1'b0;
        end
    end

    // Line history write; read-before-write is provided by the output register.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[col_eff] <= bus.iDATA;
        end
    end

    // Counter and edge-detect state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fval_q  <= 1'b0;
            dval_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            full_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            fval_q  <= bus.iFVAL;
            dval_q  <= accept;
            col_q   <= col_d;
            row_q   <= row_d;
            full_q  <= full_d;
            first_q <= first_d;
        end
    end

    // Output register: current pixel, previous-line pixel and its coordinates.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.oD0    <= '0;
            bus.oD1    <= '0;
            bus.oX     <= 1'b0;
            bus.oY     <= 1'b0;
            bus.oDVAL  <= 1'b0;
            bus.oX_CNT <= '0;
            bus.oY_CNT <= '0;
            bus.oOVF   <= 1'b0;
        end else begin
            bus.oDVAL <= accept;
            bus.oOVF  <= ovf_d;
            if (accept) begin
                bus.oD0    <= bus.iDATA;
                bus.oD1    <= (first_eff | full_eff) ? '0 : mem[col_eff];
                bus.oX_CNT <= col_eff;
                bus.oY_CNT <= row_eff;
                bus.oX     <= col_eff[0];
                bus.oY     <= row_eff[0];
            end
        end
    end
endmodule

// File: tb/tb_raw_line_buffer.sv
// Randomized scoreboard bench for raw_line_buffer with a line-level model.
module tb_raw_line_buffer;
    localparam int unsigned DW = 12;
    localparam int unsigned L  = 8;
    localparam int unsigned AW = 3;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    raw_line_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    raw_line_buffer #(.DATA_W(DW), .LINE_MAX(L), .ADDR_W(AW)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    typedef struct {
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [AW-1:0] xc;
        logic [15:0]   yc;
        logic          ovf;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_err = 0;

    // Model state: previous-line memory, row index, first-line and overflow flags.
    logic [DW-1:0] m_mem [L];
    logic [15:0]   m_row;
    bit            m_first;
    bit            m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_frame_start();
        m_row = '0; m_first = 1'b1; m_ovf = 1'b0;
    endtask

    task automatic model_pixel(input int c, input logic [DW-1:0] data);
        exp_t e;
        e.d0  = data;
        e.xc  = (c < L) ? AW'(c) : AW'(L - 1);
        e.d1  = (m_first || c >= L) ? '0 : m_mem[c];
        if (c < L) m_mem[c] = data;
        else       m_ovf = 1'b1;
        e.yc  = m_row;
        e.ovf = m_ovf;
        q.push_back(e);
    endtask

    task automatic model_eol();
        m_row = m_row + 16'd1; m_first = 1'b0;
    endtask

    task automatic px(input logic dv, input logic fv, input logic [DW-1:0] d);
        @(posedge CLK); #1;
        bus.iDVAL = dv; bus.iFVAL = fv; bus.iDATA = d;
    endtask

    task automatic frame_start();
        model_frame_start();
        px(1'b0, 1'b1, '0);
    endtask

    task automatic end_frame();
        for (int i = 0; i < 3; i++) px(1'b0, 1'b0, DW'($urandom));
    endtask

    // gap=0 leaves the line open (used before dropping iFVAL mid-line).
    task automatic send_line(input int n, input bit fixed, input logic [DW-1:0] base,
                             input int gap, input bit rise);
        logic [DW-1:0] d;
        for (int c = 0; c < n; c++) begin
            d = fixed ? DW'(base + DW'(c)) : DW'($urandom);
            if (rise && c == 0) model_frame_start();
            px(1'b1, 1'b1, d);
            model_pixel(c, d);
        end
        for (int g = 0; g < gap; g++) px(1'b0, 1'b1, DW'($urandom));
        if (gap > 0) model_eol();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d0"},   32'(bus.oD0), 0);
        chk({tag, "_d1"},   32'(bus.oD1), 0);
        chk({tag, "_dval"}, 32'(bus.oDVAL), 0);
        chk({tag, "_xy"},   32'({bus.oX, bus.oY}), 0);
        chk({tag, "_xcnt"}, 32'(bus.oX_CNT), 0);
        chk({tag, "_ycnt"}, 32'(bus.oY_CNT), 0);
        chk({tag, "_ovf"},  32'(bus.oOVF), 0);
    endtask

    // Monitor: every valid output pixel is matched against the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && bus.oDVAL) begin
            if (q.size() == 0) begin
                chk("unexpected_dval", 32'(bus.oDVAL), 0);
            end else begin
                e = q.pop_front();
                chk("oD0",    32'(bus.oD0), 32'(e.d0));
                chk("oD1",    32'(bus.oD1), 32'(e.d1));
                chk("oX_CNT", 32'(bus.oX_CNT), 32'(e.xc));
                chk("oY_CNT", 32'(bus.oY_CNT), 32'(e.yc));
                chk("oX",     32'(bus.oX), 32'(e.xc[0]));
                chk("oY",     32'(bus.oY), 32'(e.yc[0]));
                chk("oOVF",   32'(bus.oOVF), 32'(e.ovf));
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        model_frame_start();

        // Reset held while the stream is active.
        bus.iDVAL = 1'b1; bus.iFVAL = 1'b1; bus.iDATA = 12'h5A5;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1; bus.iDATA = DW'($urandom);
        end
        @(negedge CLK);
        chk_zero("rst_hold");
        bus.iDVAL = 1'b0; bus.iFVAL = 1'b0;
        @(negedge CLK); RST_N = 1'b1;

        // Directed frame: two full lines, an overflowing line, then a reader line.
        frame_start();
        send_line(8,  1'b1, 12'h100, 1, 1'b0);
        send_line(8,  1'b1, 12'h200, 1, 1'b0);
        send_line(10, 1'b1, 12'h300, 3, 1'b0);
        send_line(8,  1'b1, 12'h400, 2, 1'b0);
        end_frame();

        // iDVAL outside a frame must be ignored.
        px(1'b1, 1'b0, 12'hABC);
        px(1'b0, 1'b0, 12'h000);
        @(negedge CLK);
        chk("dval_no_fval", 32'(bus.oDVAL), 0);

        // Frame rising together with the first pixel; overflow flag must be clear.
        send_line(8, 1'b1, 12'h500, 1, 1'b1);
        send_line(5, 1'b1, 12'h600, 1, 1'b0);
        send_line(6, 1'b1, 12'h700, 0, 1'b0);
        end_frame();

        // Random frames, some cut off mid-line.
        for (int f = 0; f < 8; f++) begin
            int nl;
            bit rise;
            nl   = int'($urandom_range(1, 4));
            rise = 1'($urandom_range(0, 1));
            if (!rise) frame_start();
            for (int ln = 0; ln < nl; ln++) begin
                int gap;
                gap = int'($urandom_range(1, 3));
                if (ln == nl - 1 && $urandom_range(0, 3) == 0) gap = 0;
                send_line(int'($urandom_range(1, 10)), 1'b0, '0, gap, rise && ln == 0);
            end
            end_frame();
        end

        // Reset at column 4 of row 2.
        frame_start();
        send_line(8, 1'b0, '0, 1, 1'b0);
        send_line(8, 1'b0, '0, 1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            d = DW'(12'h800 + 12'(c));
            px(1'b1, 1'b1, d);
            model_pixel(c, d);
        end
        @(posedge CLK);
        @(negedge CLK); #2;
        bus.iDATA = 12'h804;
        RST_N = 1'b0;
        #1;
        chk_zero("rst_mid");
        chk("q_empty_at_rst", 32'(q.size()), 0);
        q.delete();
        px(1'b0, 1'b0, '0);
        px(1'b0, 1'b0, '0);
        @(negedge CLK); RST_N = 1'b1;

        // Post-reset frame is a first frame again.
        frame_start();
        send_line(8, 1'b0, '0, 1, 1'b0);
        send_line(7, 1'b0, '0, 2, 1'b0);
        end_frame();

        for (int i = 0; i < 4; i++) @(posedge CLK);
        @(negedge CLK);
        chk("q_drained", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/raw_line_buffer.md
# raw_line_buffer

Bayer line-pairing stage that sits directly upstream of the demosaic/binning stage in the D8M camera pipeline. Accepts the raw 12-bit sensor pixel stream with frame/line valids. Emits each pixel paired with the vertically adjacent pixel from the previous line, plus column/row parity and counts, one cycle later. Holds one line of history in an inferred dual-port RAM.

## Interface
- DATA_W, 12, raw pixel width
- LINE_MAX, 2048, maximum pixels per line held in the line RAM
- ADDR_W, 11, column address width; must satisfy 2**ADDR_W >= LINE_MAX
- CLK  in  1  pixel clock
- RST_N  in  1  reset, asynchronous, active-low
- iDATA  in  DATA_W  raw Bayer pixel
- iDVAL  in  1  line valid / pixel valid, high for each pixel of a line
- iFVAL  in  1  frame valid
- oD0  out  DATA_W  current-line pixel (registered iDATA)
- oD1  out  DATA_W  previous-line pixel, same column
- oX  out  1  column parity (column count bit 0)
- oY  out  1  row parity (row count bit 0)
- oDVAL  out  1  output pixel valid
- oX_CNT  out  ADDR_W  column index of output pixel
- oY_CNT  out  16  row index of output pixel
- oOVF  out  1  sticky line-overflow flag, cleared at frame start

## Operation
- Pixel accepted when iDVAL=1 and iFVAL=1; iDVAL while iFVAL=0 ignored.
- Frame start: rising edge of iFVAL (registered compare) clears column count, row count, oOVF, and sets the first-line flag.
- Per accepted pixel at column c: RAM read at c and RAM write of iDATA at c in the same cycle; read returns the old contents (read-before-write). Column count increments.
- End of line: falling edge of accepted iDVAL; column count returns to 0, row count increments (wraps at 2**16), first-line flag cleared.
- First line of frame: oD1 forced to 0 (RAM holds stale previous-frame data).
- Overflow: column count saturates at LINE_MAX-1; further pixels on that line are still output on oD0 with oDVAL=1, RAM write suppressed, oD1 forced 0, oOVF set and held until next frame start.
- iFVAL falling mid-line: counters frozen; next rising edge restarts at row 0, col 0.
- iFVAL rising and iDVAL high in the same cycle: that pixel is row 0, col 0.
- Reset: all outputs 0; column/row counters 0; first-line flag set; RAM contents not cleared.

## Timing
- Latency 1 cycle: pixel presented with iDVAL at cycle n appears on oD0/oD1/oX/oY/oX_CNT/oY_CNT/oDVAL at cycle n+1, all from the same cycle's registers.
- oDVAL = iDVAL & iFVAL delayed 1 cycle; no backpressure, one pixel per clock sustained.
- oX/oY equal bit 0 of oX_CNT/oY_CNT exactly; row 0 col 0 gives oY=0, oX=0.
- Minimum horizontal blanking: 1 cycle with iDVAL=0 between lines.
- RAM read is synchronous (registered output) so it aligns with the registered oD0.
- Reset assertion mid-line: outputs go to 0 asynchronously; first post-reset line treated as first line.

## Test plan
- Reset: hold RST_N=0 with active stream -> all outputs 0; release, drive frame with LINE_MAX=8, line 0 values 0x100..0x107 -> oD0 follows one cycle late, oD1=0, oY=0, oX alternating 0,1.
- Two lines: line 0 = 0x100+c, line 1 = 0x200+c, c=0..7 -> on line 1 oD0=0x200+c, oD1=0x100+c, oY=1, oY_CNT=1, oX_CNT=c.
- Overflow: line of 10 pixels with LINE_MAX=8 -> oOVF rises at 9th output pixel, oX_CNT stays 7, next line oD1 at cols 0..7 matches first 8 pixels; oOVF clears at next iFVAL rise.
- Frame restart: 3 lines, drop iFVAL, new frame -> oY_CNT restarts at 0, oD1=0 for whole first line despite stale RAM.
- Gaps: iDVAL with 3-cycle blanking between lines and 1-cycle min blanking -> row increments once per line, no pixel lost; iDVAL pulse while iFVAL=0 -> oDVAL stays 0, counters unchanged.
- Mid-line reset at column 4 of line 2 -> outputs 0 immediately; next frame behaves as the first (oD1=0 on row 0).
